xgxs_enc_8b10b: RTL and testbench

Registered 8b/10b line encoder for the XGXS/XAUI lane datapath. It converts one byte plus a control flag into a 10-bit code group per clock, using IBM/Widmer-Franaszek coding with running-disparity (RD) tracking. It sits between the lane's byte source and the serializer. Its output is consumed by the matching 10b/8b decoder, which must recover the original byte and K flag. It also provides hooks to inject code and disparity errors for test.

---
 rtl/xgxs_enc_8b10b.sv | 109 ++++++++++
 tb/tb_xgxs_enc_8b10b.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/xgxs_enc_8b10b.sv
// Registered 8b/10b encoder for one XGXS lane: table-driven 5b/6b + 3b/4b with
// a single running-disparity flop and code/disparity error injection.
module xgxs_enc_8b10b (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] encode_data_in,
  input  logic       konstant,
  input  logic       bad_code,
  input  logic       bad_disp,
  output logic [9:0] encode_data_out,
  output logic       disp_out
);

  logic       rd_q;
  logic       k_valid, force_err, kc, k28;
  logic [4:0] x;
  logic [2:0] y;
  logic       rd_in, rd6, rd_next;
  logic [5:0] base6, c6;   // abcdei, a in bit 5
  logic [3:0] base4, c4;   // fghj, f in bit 3
  logic       unbal6, unbal4, flip6, flip4, use_a7;
  logic [9:0] word;

  always_comb begin
    k_valid   = (encode_data_in[4:0] == 5'd28) ||
                (encode_data_in inside {8'hF7, 8'hFB, 8'hFD, 8'hFE});
    force_err = bad_code | (konstant & ~k_valid);

    // An error replaces the character with K30.7 at the true RD; bad_disp is moot then.
    if (force_err) begin
      x     = 5'd30;
      y     = 3'd7;
      kc    = 1'b1;
      rd_in = rd_q;
    end else begin
      x     = encode_data_in[4:0];
      y     = encode_data_in[7:5];
      kc    = konstant;
      rd_in = rd_q ^ bad_disp;
    end
    k28 = kc && (x == 5'd28);

    if (k28) base6 = 6'b001111;
    else begin
      case (x)
        5'd0:  base6 = 6'b100111;  5'd1:  base6 = 6'b011101;
        5'd2:  base6 = 6'b101101;  5'd3:  base6 = 6'b110001;
        5'd4:  base6 = 6'b110101;  5'd5:  base6 = 6'b101001;
        5'd6:  base6 = 6'b011001;  5'd7:  base6 = 6'b111000;
        5'd8:  base6 = 6'b111001;  5'd9:  base6 = 6'b100101;
        5'd10: base6 = 6'b010101;  5'd11: base6 = 6'b110100;
        5'd12: base6 = 6'b001101;  5'd13: base6 = 6'b101100;
        5'd14: base6 = 6'b011100;  5'd15: base6 = 6'b010111;
        5'd16: base6 = 6'b011011;  5'd17: base6 = 6'b100011;
        5'd18: base6 = 6'b010011;  5'd19: base6 = 6'b110010;
        5'd20: base6 = 6'b001011;  5'd21: base6 = 6'b101010;
        5'd22: base6 = 6'b011010;  5'd23: base6 = 6'b111010;
        5'd24: base6 = 6'b110011;  5'd25: base6 = 6'b100110;
        5'd26: base6 = 6'b010110;  5'd27: base6 = 6'b110110;
        5'd28: base6 = 6'b001110;  5'd29: base6 = 6'b101110;
        5'd30: base6 = 6'b011110;  default: base6 = 6'b101011;
      endcase
    end
    unbal6 = ($countones(base6) != 3);
    flip6  = unbal6 | ((x == 5'd7) & ~k28);
    c6     = (rd_in && flip6) ? ~base6 : base6;
    rd6    = rd_in ^ unbal6;

    use_a7 = (y == 3'd7) &&
             (kc || (!rd6 && (x inside {5'd17, 5'd18, 5'd20})) ||
                    ( rd6 && (x inside {5'd11, 5'd13, 5'd14})));
    if (use_a7) base4 = 4'b0111;
    else if (k28) begin
      // K28 inverts the balanced 4b codes relative to data to form the comma.
      case (y)
        3'd0: base4 = 4'b1011;  3'd1: base4 = 4'b0110;
        3'd2: base4 = 4'b1010;  3'd3: base4 = 4'b1100;
        3'd4: base4 = 4'b1101;  3'd5: base4 = 4'b0101;
        default: base4 = 4'b1001;
      endcase
    end else begin
      case (y)
        3'd0: base4 = 4'b1011;  3'd1: base4 = 4'b1001;
        3'd2: base4 = 4'b0101;  3'd3: base4 = 4'b1100;
        3'd4: base4 = 4'b1101;  3'd5: base4 = 4'b1010;
        3'd6: base4 = 4'b0110;  default: base4 = 4'b1110;
      endcase
    end
    unbal4  = ($countones(base4) != 2);
    flip4   = unbal4 | (base4 == 4'b1100) | k28;
    c4      = (rd6 && flip4) ? ~base4 : base4;
    rd_next = rd6 ^ unbal4;

    word = {c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      encode_data_out <= '0;
      rd_q            <= 1'b0;
    end else begin
      encode_data_out <= word;
      rd_q            <= rd_next;
    end
  end

  assign disp_out = rd_q;

endmodule

// File: tb/tb_xgxs_enc_8b10b.sv
// Directed bench for xgxs_enc_8b10b: hand-computed code groups plus a
// byte sweep checked by a small disparity-aware reference decoder.
module tb_xgxs_enc_8b10b;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       konst, bc, bd;
  logic [9:0] dout;
  logic       disp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xgxs_enc_8b10b dut (
    .clk            (clk),
    .rst            (rst),
    .encode_data_in (din),
    .konstant       (konst),
    .bad_code       (bc),
    .bad_disp       (bd),
    .encode_data_out(dout),
    .disp_out       (disp)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic k, input logic c, input logic d);
    din = b; konst = k; bc = c; bd = d;
    @(posedge clk); #1;
  endtask

  task automatic send_chk(input string tag, input logic [7:0] b, input logic k,
                          input logic c, input logic d, input logic [9:0] exp_w,
                          input logic exp_rd);
    send(b, k, c, d);
    check(tag, dout, exp_w);
    check({tag, "_rd"}, disp, exp_rd);
  endtask

  // Standard 5b/6b codes for RD-, abcdei with a in bit 5
  function automatic logic [5:0] t6(input logic [4:0] x);
    case (x)
      5'd0:  t6 = 6'b100111;  5'd1:  t6 = 6'b011101;  5'd2:  t6 = 6'b101101;
      5'd3:  t6 = 6'b110001;  5'd4:  t6 = 6'b110101;  5'd5:  t6 = 6'b101001;
      5'd6:  t6 = 6'b011001;  5'd7:  t6 = 6'b111000;  5'd8:  t6 = 6'b111001;
      5'd9:  t6 = 6'b100101;  5'd10: t6 = 6'b010101;  5'd11: t6 = 6'b110100;
      5'd12: t6 = 6'b001101;  5'd13: t6 = 6'b101100;  5'd14: t6 = 6'b011100;
      5'd15: t6 = 6'b010111;  5'd16: t6 = 6'b011011;  5'd17: t6 = 6'b100011;
      5'd18: t6 = 6'b010011;  5'd19: t6 = 6'b110010;  5'd20: t6 = 6'b001011;
      5'd21: t6 = 6'b101010;  5'd22: t6 = 6'b011010;  5'd23: t6 = 6'b111010;
      5'd24: t6 = 6'b110011;  5'd25: t6 = 6'b100110;  5'd26: t6 = 6'b010110;
      5'd27: t6 = 6'b110110;  5'd28: t6 = 6'b001110;  5'd29: t6 = 6'b101110;
      5'd30: t6 = 6'b011110;  default: t6 = 6'b101011;
    endcase
  endfunction

  function automatic logic [3:0] p4(input logic [2:0] y);
    case (y)
      3'd0: p4 = 4'b1011; 3'd1: p4 = 4'b1001; 3'd2: p4 = 4'b0101; 3'd3: p4 = 4'b1100;
      3'd4: p4 = 4'b1101; 3'd5: p4 = 4'b1010; 3'd6: p4 = 4'b0110; default: p4 = 4'b1110;
    endcase
  endfunction

  function automatic logic [3:0] k4(input logic [2:0] y);
    case (y)
      3'd0: k4 = 4'b1011; 3'd1: k4 = 4'b0110; 3'd2: k4 = 4'b1010; 3'd3: k4 = 4'b1100;
      3'd4: k4 = 4'b1101; 3'd5: k4 = 4'b0101; 3'd6: k4 = 4'b1001; default: k4 = 4'b0111;
    endcase
  endfunction

  // 0..31 data sub-block, 128 for K28, -1 for an invalid group
  function automatic int dec6(input logic [5:0] c);
    int r;
    logic [5:0] t;
    r = -1;
    if (c == 6'b001111 || c == 6'b110000) r = 128;
    else
      for (int x = 0; x < 32; x++) begin
        t = t6(x[4:0]);
        if (c == t || (c == ~t && ($countones(t) != 3 || x == 7))) r = x;
      end
    return r;
  endfunction

  function automatic logic legal6(input logic [5:0] c, input logic rd);
    case ($countones(c))
      3:       legal6 = !(c == 6'b000111 && !rd) && !(c == 6'b111000 && rd);
      4:       legal6 = !rd;
      2:       legal6 = rd;
      default: legal6 = 1'b0;
    endcase
  endfunction

  function automatic logic legal4(input logic [3:0] c, input logic rd);
    case ($countones(c))
      2:       legal4 = !(c == 4'b0011 && !rd) && !(c == 4'b1100 && rd);
      3:       legal4 = !rd;
      1:       legal4 = rd;
      default: legal4 = 1'b0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       k, kd, a7, rd_m, rd4, a7_rule, bad;
    logic [5:0] a6;
    logic [3:0] f4, e4;
    int         xd, xv, yd;

    rst = 1'b1; din = '0; konst = 1'b0; bc = 1'b0; bd = 1'b0;
    #12;
    check("rst_word", dout, 10'h000);
    check("rst_rd", disp, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    send_chk("d0_0",        8'h00, 1'b0, 1'b0, 1'b0, 10'h0B9, 1'b0);
    send_chk("k28_5_m",     8'hBC, 1'b1, 1'b0, 1'b0, 10'h17C, 1'b1);
    send_chk("k28_5_p",     8'hBC, 1'b1, 1'b0, 1'b0, 10'h283, 1'b0);
    send_chk("d21_5_m",     8'hB5, 1'b0, 1'b0, 1'b0, 10'h155, 1'b0);
    send_chk("k28_5_m2",    8'hBC, 1'b1, 1'b0, 1'b0, 10'h17C, 1'b1);
    send_chk("d21_5_p",     8'hB5, 1'b0, 1'b0, 1'b0, 10'h155, 1'b1);
    send_chk("badcode_p",   8'h26, 1'b0, 1'b1, 1'b0, 10'h3A1, 1'b1);
    send_chk("k28_5_p2",    8'hBC, 1'b1, 1'b0, 1'b0, 10'h283, 1'b0);
    send_chk("badcode_m",   8'h26, 1'b0, 1'b1, 1'b0, 10'h05E, 1'b0);
    send_chk("badk_m",      8'h26, 1'b1, 1'b0, 1'b0, 10'h05E, 1'b0);
    send_chk("baddisp_m",   8'h00, 1'b0, 1'b0, 1'b1, 10'h346, 1'b1);
    send_chk("d0_0_p",      8'h00, 1'b0, 1'b0, 1'b0, 10'h346, 1'b1);
    send_chk("k28_5_p3",    8'hBC, 1'b1, 1'b0, 1'b0, 10'h283, 1'b0);
    send_chk("d17_7_m",     8'hF1, 1'b0, 1'b0, 1'b0, 10'h3B1, 1'b1);
    send_chk("d11_7_p",     8'hEB, 1'b0, 1'b0, 1'b0, 10'h04B, 1'b0);
    send_chk("bc_over_bd",  8'h00, 1'b0, 1'b1, 1'b1, 10'h05E, 1'b0);
    send_chk("k28_5_m3",    8'hBC, 1'b1, 1'b0, 1'b0, 10'h17C, 1'b1);

    // Asynchronous reset in the middle of a cycle
    din = 8'hB5; konst = 1'b0; bc = 1'b0; bd = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_word", dout, 10'h000);
    check("mid_rst_rd", disp, 1'b0);
    @(posedge clk); #1;
    check("mid_rst_hold", dout, 10'h000);
    #2 rst = 1'b0;
    @(negedge clk);
    send_chk("d0_0_after_rst", 8'h00, 1'b0, 1'b0, 1'b0, 10'h0B9, 1'b0);

    rd_m = 1'b0;
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      k = (b == 8'h1C || b == 8'h7C || b == 8'hBC);
      send(b, k, 1'b0, 1'b0);
      a6 = {dout[0], dout[1], dout[2], dout[3], dout[4], dout[5]};
      f4 = {dout[6], dout[7], dout[8], dout[9]};

      check("legal6", legal6(a6, rd_m), 1'b1);
      rd4 = rd_m ^ ($countones(a6) != 3);
      check("legal4", legal4(f4, rd4), 1'b1);

      xd = dec6(a6);
      kd = (xd == 128);
      xv = kd ? 28 : xd;
      yd = -1;
      a7 = 1'b0;
      if (f4 == (rd4 ? 4'b1000 : 4'b0111)) begin
        yd = 7;
        a7 = 1'b1;
      end else
        for (int y = 0; y < 7; y++) begin
          if (kd) e4 = rd4 ? ~k4(y[2:0]) : k4(y[2:0]);
          else begin
            e4 = p4(y[2:0]);
            if ($countones(e4) != 2 || e4 == 4'b1100) e4 = rd4 ? ~e4 : e4;
          end
          if (f4 == e4) yd = y;
        end
      if (yd < 0)
        for (int y = 7; y < 8; y++) begin
          e4 = rd4 ? ~p4(y[2:0]) : p4(y[2:0]);
          if (!kd && f4 == e4) yd = y;
        end
      if (!kd && a7 && (xv == 23 || xv == 27 || xv == 29 || xv == 30)) kd = 1'b1;
      rd_m = rd4 ^ ($countones(f4) != 2);

      bad = (xd < 0) || (yd < 0);
      check("dec_byte", {7'd0, bad, yd[2:0], xv[4:0]}, {8'd0, b});
      check("dec_k", kd, k);
      check("disp_track", disp, rd_m);
      if (!k && b[7:5] == 3'd7) begin
        a7_rule = (!rd4 && (b[4:0] == 5'd17 || b[4:0] == 5'd18 || b[4:0] == 5'd20)) ||
                  ( rd4 && (b[4:0] == 5'd11 || b[4:0] == 5'd13 || b[4:0] == 5'd14));
        check("a7_select", a7, a7_rule);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
